// File: rtl/irq_req_ack_ctrl.sv
// Interrupt pending buffer with a REQ/ACK handshake towards the core.
// Pending lines are latched, masked for the external id arbiter, and offered one at a time.
module irq_req_ack_ctrl #(
    parameter int NUM_IRQ = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] event_set_i,
    input  logic [63:0] clear_i,
    input  logic [63:0] irq_mask_i,
    output logic [63:0] buffer_status_o,
    input  logic [7:0]  irq_id_i,
    output logic        irq_req_o,
    output logic [7:0]  irq_id_o,
    input  logic        irq_ack_i,
    input  logic [7:0]  irq_ack_id_i,
    output logic        ack_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_e;

    localparam logic [7:0] ID_LIMIT = 8'(NUM_IRQ);
    localparam logic [7:0] ID_NONE  = 8'hFF;

    state_e      state_q, state_d;
    logic [63:0] pend_q, pend_d;
    logic [7:0]  irq_id_q, irq_id_d;
    logic        ack_err_q, ack_err_d;
    logic [63:0] impl_mask;
    logic [63:0] ack_clr_vec;

    // Lines at or above NUM_IRQ are never stored.
    for (genvar gi = 0; gi < 64; gi++) begin : g_impl
        assign impl_mask[gi] = (gi < NUM_IRQ) ? 1'b1 : 1'b0;
    end

    always_comb begin
        ack_clr_vec = '0;
        if (irq_ack_i && (state_q == ST_REQ) && (irq_ack_id_i < ID_LIMIT)) begin
            ack_clr_vec[irq_ack_id_i[5:0]] = 1'b1;
        end
    end

    // Set is OR-ed in last so it wins over any clear of the same bit.
    assign pend_d = ((pend_q & ~(clear_i | ack_clr_vec)) | event_set_i) & impl_mask;

    assign ack_err_d = irq_ack_i && ((state_q != ST_REQ) || (irq_ack_id_i != irq_id_q));

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_id_i < ID_LIMIT) begin
                    state_d  = ST_REQ;
                    irq_id_d = irq_id_i;
                end
            end
            ST_REQ: begin
                // Acknowledge takes precedence over a same-cycle software withdrawal.
                if (irq_ack_i) begin
                    state_d  = ST_GAP;
                    irq_id_d = ID_NONE;
                end else if (!pend_d[irq_id_q[5:0]]) begin
                    state_d  = ST_IDLE;
                    irq_id_d = ID_NONE;
                end
            end
            ST_GAP: begin
                state_d  = ST_IDLE;
                irq_id_d = ID_NONE;
            end
            default: begin
                state_d  = ST_IDLE;
                irq_id_d = ID_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            irq_id_q  <= ID_NONE;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            irq_id_q  <= irq_id_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign buffer_status_o = pend_q & irq_mask_i;
    assign irq_req_o       = (state_q == ST_REQ);
    assign irq_id_o        = irq_id_q;
    assign ack_err_o       = ack_err_q;

endmodule

// File: doc/irq_req_ack_ctrl.md
IRQ_REQ_ACK_CTRL -- requirements
Module: irq_req_ack_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 64, SHALL give the number of implemented interrupt lines (legal range 1..64); bits at and above NUM_IRQ SHALL read 0 and ignore set/clear.
REQ-002 Port clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_i  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 Port event_set_i  input  64  SHALL be one-cycle set pulses, one per interrupt line.
REQ-005 Port clear_i  input  64  SHALL be software clear pulses, one per line.
REQ-006 Port irq_mask_i  input  64  SHALL be the enable mask (1 = enabled).
REQ-007 Port buffer_status_o  output  64  SHALL be the masked pending vector sent to the id arbiter.
REQ-008 Port irq_id_i  input  8  SHALL be the lowest pending id from the arbiter; 8'hFF means none pending.
REQ-009 Port irq_req_o  output  1  SHALL be the interrupt request to the core.
REQ-010 Port irq_id_o  output  8  SHALL be the id offered to the core.
REQ-011 Port irq_ack_i  input  1  SHALL be the one-cycle core acknowledge.
REQ-012 Port irq_ack_id_i  input  8  SHALL be the id the core acknowledges; valid only with irq_ack_i.
REQ-013 Port ack_err_o  output  1  SHALL pulse for one cycle on an acknowledge protocol error.

Function
REQ-014 Pending register P[63:0] SHALL update each cycle as P = (P & ~clr) | event_set_i, clr = clear_i | ack-clear bit; set SHALL win over a simultaneous clear of the same bit.
REQ-015 Ack-clear bit SHALL be bit irq_ack_id_i when irq_ack_i=1, state is REQ and irq_ack_id_i < NUM_IRQ; otherwise none.
REQ-016 buffer_status_o SHALL equal P & irq_mask_i, combinational from registered P (one-cycle latency from event_set_i).
REQ-017 FSM states SHALL be IDLE, REQ, GAP.
REQ-018 IDLE: if irq_id_i < NUM_IRQ, next state REQ and irq_id_o <= irq_id_i; otherwise stay IDLE. irq_id_i = 8'hFF or any id >= NUM_IRQ SHALL be treated as no request.
REQ-019 irq_req_o SHALL be 1 exactly while in REQ; irq_id_o SHALL stay constant throughout REQ, even if a lower id becomes pending.
REQ-020 REQ with irq_ack_i=1: apply ack-clear, next state GAP.
REQ-021 REQ with irq_ack_i=0 and P[irq_id_o]=0 after that cycle's clear_i (withdrawn by software clear or mask irrelevant): next state IDLE, irq_id_o <= 8'hFF; mask changes SHALL NOT withdraw a request.
REQ-022 Acknowledge and withdrawal in the same cycle: acknowledge SHALL win (GAP).
REQ-023 GAP: irq_req_o=0, irq_id_o <= 8'hFF, unconditional next state IDLE; guarantees the arbiter sees the cleared buffer before the next sample.
REQ-024 ack_err_o SHALL pulse the cycle after irq_ack_i=1 when state is not REQ, or irq_ack_id_i != irq_id_o; the ack-clear SHALL still apply if in REQ and id < NUM_IRQ, and the FSM SHALL still move to GAP.
REQ-025 Minimum request-to-request spacing SHALL be 3 cycles (REQ ack cycle, GAP, IDLE sample).

Reset
REQ-026 On rst_i=1, asynchronously: P=0, state IDLE, irq_req_o=0, irq_id_o=8'hFF, ack_err_o=0, buffer_status_o=0.
REQ-027 Reset asserted mid-request SHALL drop irq_req_o immediately and discard all pending lines; first request after release SHALL need a fresh event_set_i.

Verification
REQ-028 Mask all ones, pulse event_set_i[5] -> buffer_status_o[5]=1 next cycle; arbiter returns 5 -> irq_req_o=1, irq_id_o=5; irq_ack_i with id 5 -> P[5]=0, GAP, irq_id_o=8'hFF, ack_err_o=0.
REQ-029 Pending 5, in REQ on id 5, set line 2 -> irq_id_o stays 5 until ack; after GAP, new request with id 2 on the third cycle after ack.
REQ-030 In REQ on id 9, clear_i[9] without ack -> irq_req_o=0 next cycle, IDLE, irq_id_o=8'hFF; same with irq_ack_i in that cycle -> GAP, no withdrawal.
REQ-031 Ack with id 7 while irq_id_o=3 -> ack_err_o one-cycle pulse, P[7] cleared, P[3] kept, FSM to GAP then re-requests 3; ack in IDLE -> ack_err_o pulse, P unchanged.
REQ-032 event_set_i[4] and clear_i[4] together, and event_set_i[4] during ack of id 4 -> P[4]=1 afterwards.
REQ-033 NUM_IRQ=8, set line 12 and irq_id_i=12 -> P unchanged, no request; rst_i asserted in REQ -> irq_req_o=0 same cycle, all outputs at reset values.
